dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Sits directly downstream of the single-cycle datapath's data-memory port, between the CPU-side dmem bus and a variable-latency data SRAM/bus port.
- Turns the single-cycle load/store into a req/ready + rvalid transaction.
- Posts stores through a single-entry write buffer and forwards from it.
- Drives `stall`, which freezes the PC and register writes while a load is outstanding or a store cannot be accepted.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits; word = DW/8 bytes; word address = addr[AW-1:2].

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cpu_addr  in  AW  byte address from the ALU result; addr[1:0] ignored.
- cpu_wdata  in  DW  store data from the rt register.
- cpu_we  in  1  store request; held stable by the CPU while stall=1.
- cpu_re  in  1  load request; held stable by the CPU while stall=1.
- cpu_rdata  out  DW  load data; valid in the cycle stall deasserts for a load.
- stall  out  1  CPU must hold PC and inputs and suppress the register write.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = write, 0 = read; valid while mem_req=1.
- mem_addr  out  AW  word-aligned address, bits [1:0] = 0.
- mem_wdata  out  DW  write data.
- mem_ready  in  1  memory accepts the request this cycle (handshake = mem_req & mem_ready).
- mem_rvalid  in  1  read data valid; at least 1 cycle after the read handshake.
- mem_rdata  in  DW  read data.

Behaviour:
- Reset (async assert) and state after it:
  - all outputs 0; FSM = IDLE; wbuf_valid = 0; rd_reg = 0.
  - Reset mid-transaction abandons it; mem_req drops immediately.
  - An mem_rvalid arriving after reset release with no read outstanding is ignored.
- FSM states:
  - IDLE: no read in flight. Write buffer drains from here.
  - RD_REQ: mem_req=1, mem_we=0, mem_addr=cpu word address; on handshake → RD_WAIT.
  - RD_WAIT: mem_req=0; on mem_rvalid, rd_reg <= mem_rdata → RD_DONE.
  - RD_DONE: stall=0, cpu_rdata=rd_reg for exactly 1 cycle → IDLE.
- Request stability:
  - mem_req/mem_we/mem_addr/mem_wdata stay stable from assertion until handshake.
  - mem_req never drops without a handshake, except on reset.
- Store (cpu_we=1, IDLE):
  - Buffer empty, or draining with handshake this cycle: capture {word addr, data} into wbuf, stall=0.
  - Otherwise stall=1 until it can capture.
- Drain:
  - Whenever wbuf_valid=1 and FSM is IDLE: mem_req=1, mem_we=1, addr/data from wbuf.
  - Handshake clears wbuf_valid unless a new store is captured the same cycle, in which case wbuf_valid stays 1 with the new contents.
- Load (cpu_re=1, IDLE):
  - wbuf_valid and word addresses match: stall=0, cpu_rdata=wbuf data combinationally, no mem access.
  - wbuf_valid, no match: stall=1 until drained (ordering preserved), then go to RD_REQ.
  - wbuf empty: stall=1, next state RD_REQ.
  - stall stays 1 through RD_REQ and RD_WAIT; 0 in RD_DONE.
- Load latency: with mem_ready=1 and mem_rvalid one cycle after the handshake, stall=1 for exactly 3 cycles (IDLE, RD_REQ, RD_WAIT); RD_DONE is the 4th cycle.
- cpu_we and cpu_re both 1: treated as a store; the load is ignored.
- cpu_rdata outside load completion/forwarding is 0.
- stall is combinational from state, inputs and wbuf; it never depends combinationally on mem_rdata.

Decomposition:
- Package dmem_bridge_pkg:
  - state enum {IDLE, RD_REQ, RD_WAIT, RD_DONE};
  - localparam WORD_LSB = 2;
  - word-address-match function.
- Sub-module dmem_wbuf:
  - single-entry buffer with capture/clear ports;
  - exposes valid/addr/data and the match compare.

Test Plan:
- Store 0xDEADBEEF to 0x100, mem_ready=1 → stall=0; next cycle mem_req=1, mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF; then wbuf_valid=0.
- Store 0xDEADBEEF to 0x100 with mem_ready=0, then load 0x102 → stall=0, cpu_rdata=0xDEADBEEF, no read request issued.
- Load 0x200, mem_ready=1, mem_rvalid=1 one cycle after handshake with 0x12345678 → stall high exactly 3 cycles; RD_DONE cycle cpu_rdata=0x12345678.
- Store A, then store B with mem_ready held 0 for 5 cycles → second store stalls 5 cycles; B captured on A's handshake cycle; memory sees A then B.
- Store to 0x300 (mem_ready=0), then load 0x400 → stall until the write handshake; read to 0x400 issued after, never before.
- Assert reset_n=0 during RD_WAIT, release, then pulse a stale mem_rvalid → outputs 0 immediately; FSM IDLE; stale rvalid ignored; stall=0.

Source files
------------

// File: rtl/dmem_bridge_pkg.sv
// Shared types and helpers for the data-memory bridge between the CPU dmem port and a
// variable-latency memory.
package dmem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    RD_DONE
  } state_e;

  localparam int unsigned WORD_LSB = 2;
  localparam int unsigned MAX_AW   = 64;

  // Word-granular address compare; callers zero-extend to MAX_AW.
  function automatic logic word_match(input logic [MAX_AW-1:0] a,
                                      input logic [MAX_AW-1:0] b);
    return a[MAX_AW-1:WORD_LSB] == b[MAX_AW-1:WORD_LSB];
  endfunction

endpackage

// File: rtl/dmem_wbuf.sv
// Single-entry posted-store buffer.
// A capture that lands in the same cycle as a clear wins, so the buffer stays full.
module dmem_wbuf
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          capture_i,
  input  logic          clear_i,
  input  logic [AW-1:0] cap_addr_i,
  input  logic [DW-1:0] cap_data_i,
  input  logic [AW-1:0] lookup_addr_i,
  output logic          valid_o,
  output logic [AW-1:0] addr_o,
  output logic [DW-1:0] data_o,
  output logic          match_o
);

  logic                   valid_q;
  logic [AW-WORD_LSB-1:0] waddr_q;
  logic [DW-1:0]          data_q;
  logic                   unused_cap_lsb;

  assign unused_cap_lsb = ^cap_addr_i[WORD_LSB-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
    end else if (capture_i) begin
      valid_q <= 1'b1;
      waddr_q <= cap_addr_i[AW-1:WORD_LSB];
      data_q  <= cap_data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = {waddr_q, {WORD_LSB{1'b0}}};
  assign data_o  = data_q;
  assign match_o = valid_q & word_match(MAX_AW'(addr_o), MAX_AW'(lookup_addr_i));

endmodule

// File: rtl/dmem_bridge.sv
// Converts the single-cycle dmem load/store into req/ready + rvalid transactions,
// posting stores through a one-entry buffer that also forwards to loads.
module dmem_bridge
  import dmem_bridge_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  input  logic          cpu_we,
  input  logic          cpu_re,
  output logic [DW-1:0] cpu_rdata,
  output logic          stall,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ready,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata
);

  state_e        state_q;
  logic [DW-1:0] rd_q;
  logic          wb_valid;
  logic [AW-1:0] wb_addr;
  logic [DW-1:0] wb_data;
  logic          wb_match;
  logic          wb_capture;
  logic          wb_clear;
  logic          rd_start;

  dmem_wbuf #(.AW(AW), .DW(DW)) u_wbuf (
    .clk          (clk),
    .reset_n      (reset_n),
    .capture_i    (wb_capture),
    .clear_i      (wb_clear),
    .cap_addr_i   (cpu_addr),
    .cap_data_i   (cpu_wdata),
    .lookup_addr_i(cpu_addr),
    .valid_o      (wb_valid),
    .addr_o       (wb_addr),
    .data_o       (wb_data),
    .match_o      (wb_match)
  );

  // Memory request, CPU stall/data and buffer control from state, CPU inputs and buffer.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    stall      = 1'b0;
    cpu_rdata  = '0;
    wb_capture = 1'b0;
    wb_clear   = 1'b0;
    rd_start   = 1'b0;
    case (state_q)
      IDLE: begin
        if (wb_valid) begin
          mem_req   = 1'b1;
          mem_we    = 1'b1;
          mem_addr  = wb_addr;
          mem_wdata = wb_data;
          wb_clear  = mem_ready;
        end
        // A store wins over a simultaneous load.
        if (cpu_we) begin
          if (!wb_valid || mem_ready) wb_capture = 1'b1;
          else                        stall      = 1'b1;
        end else if (cpu_re) begin
          if (wb_match) begin
            cpu_rdata = wb_data;
          end else begin
            stall    = 1'b1;
            rd_start = !wb_valid || mem_ready;
          end
        end
      end
      RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = {cpu_addr[AW-1:WORD_LSB], {WORD_LSB{1'b0}}};
        stall    = 1'b1;
      end
      RD_WAIT: stall = 1'b1;
      RD_DONE: cpu_rdata = rd_q;
      default: ;
    endcase
  end

  // Read-transaction sequencing and load data capture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      rd_q    <= '0;
    end else begin
      case (state_q)
        IDLE:    if (rd_start) state_q <= RD_REQ;
        RD_REQ:  if (mem_ready) state_q <= RD_WAIT;
        RD_WAIT: if (mem_rvalid) begin
          rd_q    <= mem_rdata;
          state_q <= RD_DONE;
        end
        RD_DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized bench for dmem_bridge: a CPU driver plus a
// variable-latency memory, checked against a program-order memory image.
module tb_dmem_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_we, cpu_re;
  logic [DW-1:0] cpu_rdata;
  logic          stall;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready, mem_rvalid;
  logic [DW-1:0] mem_rdata;

  dmem_bridge #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_we    (cpu_we),
    .cpu_re    (cpu_re),
    .cpu_rdata (cpu_rdata),
    .stall     (stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rvalid(mem_rvalid),
    .mem_rdata (mem_rdata)
  );

  initial forever #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  int          n_vec, n_err;
  int          ready_pct, ready_zero, lat_min, lat_max;
  bit          rd_pending;
  logic [31:0] rd_addr;
  int          rd_delay;
  logic [31:0] sim_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  wr_t         exp_wq [$];
  bit          req_hold;
  logic        hold_we;
  logic [31:0] hold_addr, hold_data;

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return {w[13:0], w[17:0]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] sim_get(input logic [29:0] w);
    return sim_mem.exists(w) ? sim_mem[w] : init_val(w);
  endfunction

  function automatic logic [31:0] ref_get(input logic [29:0] w);
    return ref_mem.exists(w) ? ref_mem[w] : init_val(w);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_mem();
    if (ready_zero > 0) begin
      mem_ready = 1'b0;
      ready_zero--;
    end else begin
      mem_ready = (int'($urandom_range(99)) < ready_pct);
    end
    mem_rvalid = 1'b0;
    mem_rdata  = $urandom;
    if (rd_pending) begin
      if (rd_delay == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = sim_get(rd_addr[31:2]);
      end else begin
        rd_delay--;
      end
    end
  endtask

  // Observe the memory side of the settled cycle, advance one clock, drive memory inputs.
  task automatic tick();
    wr_t w;
    if (req_hold) begin
      check("req_held", 64'(mem_req), 64'(1));
      check("req_we_held", 64'(mem_we), 64'(hold_we));
      check("req_addr_held", 64'(mem_addr), 64'(hold_addr));
      if (hold_we) check("req_data_held", 64'(mem_wdata), 64'(hold_data));
    end
    if (mem_req) check("addr_align", 64'(mem_addr[1:0]), 64'(0));
    if (mem_rvalid) rd_pending = 1'b0;
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        if (exp_wq.size() == 0) begin
          check("unexpected_write", 64'(mem_addr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          w = exp_wq.pop_front();
          check("wr_addr", 64'(mem_addr), 64'(w.a));
          check("wr_data", 64'(mem_wdata), 64'(w.d));
        end
        sim_mem[mem_addr[31:2]] = mem_wdata;
      end else begin
        check("rd_after_drain", 64'(exp_wq.size()), 64'(0));
        check("rd_single", 64'(rd_pending), 64'(0));
        rd_pending = 1'b1;
        rd_addr    = mem_addr;
        rd_delay   = int'($urandom_range(lat_max, lat_min)) - 1;
      end
      req_hold = 1'b0;
    end else if (mem_req) begin
      req_hold  = 1'b1;
      hold_we   = mem_we;
      hold_addr = mem_addr;
      hold_data = mem_wdata;
    end else begin
      req_hold = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    drive_mem();
  endtask

  task automatic do_idle();
    cpu_we = 1'b0;
    cpu_re = 1'b0;
    #1;
    check("idle_stall", 64'(stall), 64'(0));
    check("idle_rdata", 64'(cpu_rdata), 64'(0));
    tick();
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input bit also_re,
                          output int stalls);
    bit done = 1'b0;
    cpu_addr = a; cpu_wdata = d; cpu_we = 1'b1; cpu_re = also_re;
    stalls = 0;
    for (int i = 0; i < 200; i++) begin
      #1;
      check("st_rdata_zero", 64'(cpu_rdata), 64'(0));
      if (!stall) begin
        exp_wq.push_back('{a: {a[31:2], 2'b00}, d: d});
        ref_mem[a[31:2]] = d;
        tick();
        done = 1'b1;
        break;
      end
      stalls++;
      tick();
    end
    if (!done) check("st_timeout", 64'(stalls), 64'(0));
    cpu_we = 1'b0;
    cpu_re = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, output logic [31:0] d, output int stalls);
    bit done = 1'b0;
    cpu_addr = a; cpu_wdata = $urandom; cpu_we = 1'b0; cpu_re = 1'b1;
    stalls = 0;
    d = '0;
    for (int i = 0; i < 200; i++) begin
      #1;
      if (!stall) begin
        d = cpu_rdata;
        check("ld_data", 64'(cpu_rdata), 64'(ref_get(a[31:2])));
        tick();
        done = 1'b1;
        break;
      end
      check("ld_stall_rdata0", 64'(cpu_rdata), 64'(0));
      stalls++;
      tick();
    end
    if (!done) check("ld_timeout", 64'(stalls), 64'(0));
    cpu_re = 1'b0;
  endtask

  initial begin
    int          s;
    logic [31:0] d, a;
    n_vec = 0; n_err = 0;
    ready_pct = 100; ready_zero = 0; lat_min = 1; lat_max = 1;
    rd_pending = 1'b0; req_hold = 1'b0; rd_delay = 0;
    reset_n = 1'b0;
    cpu_addr = '0; cpu_wdata = '0; cpu_we = 1'b0; cpu_re = 1'b0;
    mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req", 64'(mem_req), 64'(0));
    check("rst_mem_we", 64'(mem_we), 64'(0));
    check("rst_mem_addr", 64'(mem_addr), 64'(0));
    check("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    check("rst_stall", 64'(stall), 64'(0));
    check("rst_rdata", 64'(cpu_rdata), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);
    drive_mem();

    // Posted store, then drain on the following cycle.
    do_store(32'h100, 32'hDEAD_BEEF, 1'b0, s);
    check("st_post_stall", 64'(s), 64'(0));
    #1;
    check("drain_req", 64'(mem_req), 64'(1));
    check("drain_we", 64'(mem_we), 64'(1));
    check("drain_addr", 64'(mem_addr), 64'(32'h100));
    check("drain_data", 64'(mem_wdata), 64'(32'hDEAD_BEEF));
    tick();
    #1;
    check("drained_req", 64'(mem_req), 64'(0));
    tick();

    // Forwarding from a buffered store while memory is not ready.
    ready_pct = 0;
    do_store(32'h100, 32'hDEAD_BEEF, 1'b0, s);
    do_load(32'h102, d, s);
    check("fwd_stall", 64'(s), 64'(0));
    check("fwd_data", 64'(d), 64'(32'hDEAD_BEEF));
    check("fwd_no_read", 64'(rd_pending), 64'(0));
    ready_pct = 100;
    repeat (2) do_idle();

    // Load miss with ideal memory: three stall cycles.
    sim_mem[30'h80] = 32'h1234_5678;
    ref_mem[30'h80] = 32'h1234_5678;
    do_load(32'h200, d, s);
    check("ld_lat_stall", 64'(s), 64'(3));
    check("ld_lat_data", 64'(d), 64'(32'h1234_5678));

    // Back-to-back stores with memory busy five cycles.
    ready_zero = 5;
    do_store(32'h600, 32'h0A0A_0A0A, 1'b0, s);
    check("stA_stall", 64'(s), 64'(0));
    do_store(32'h604, 32'h0B0B_0B0B, 1'b0, s);
    check("stB_stall", 64'(s), 64'(5));
    repeat (2) do_idle();
    check("stAB_drained", 64'(exp_wq.size()), 64'(0));

    // Load miss must wait for the pending store drain.
    ready_zero = 4;
    do_store(32'h300, 32'h3333_0300, 1'b0, s);
    do_load(32'h400, d, s);
    check("ld_after_wr_stall", 64'(s), 64'(7));

    // Reset while a read is outstanding; a stale rvalid must be ignored.
    lat_min = 6; lat_max = 6;
    cpu_addr = 32'h500; cpu_we = 1'b0; cpu_re = 1'b1;
    #1; tick();
    #1; tick();
    check("rw_pending", 64'(rd_pending), 64'(1));
    reset_n = 1'b0;
    cpu_re  = 1'b0;
    #1;
    check("rstmid_req", 64'(mem_req), 64'(0));
    check("rstmid_we", 64'(mem_we), 64'(0));
    check("rstmid_addr", 64'(mem_addr), 64'(0));
    check("rstmid_stall", 64'(stall), 64'(0));
    check("rstmid_rdata", 64'(cpu_rdata), 64'(0));
    req_hold = 1'b0;
    tick();
    reset_n  = 1'b1;
    rd_delay = 0;
    do_idle();
    do_idle();
    check("stale_consumed", 64'(rd_pending), 64'(0));
    do_idle();
    lat_min = 1; lat_max = 1;
    do_load(32'h500, d, s);
    check("post_rst_ld_stall", 64'(s), 64'(3));

    // Randomized mix against the program-order memory image.
    ready_pct = 70; lat_min = 1; lat_max = 3;
    for (int i = 0; i < 250; i++) begin
      int unsigned op;
      op = $urandom_range(9);
      a  = 32'h800 + 32'($urandom_range(7)) * 4 + 32'($urandom_range(3));
      if (op <= 3)      do_store(a, $urandom, 1'b0, s);
      else if (op <= 7) do_load(a, d, s);
      else if (op == 8) do_store(a, $urandom, 1'b1, s);
      else              do_idle();
    end
    ready_pct = 100;
    repeat (3) do_idle();
    check("final_drained", 64'(exp_wq.size()), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
